// File: rtl/two_one_mux.sv
// two_one_mux: 64-bit 2:1 datapath selector.
//   data_out          : combinational select, zero latency, ignores clk/rst.
//   data_out_q, sel_q : one-cycle registered copies for pipelined consumers.
//   toggle_cnt        : saturating count of edges where en differed from sel_q.
// Optional feature macro: MUX_PARITY_EN (adds parity / parity_q outputs).
module two_one_mux #(
  parameter int WIDTH     = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [WIDTH-1:0]     data_out,
  input  logic [WIDTH-1:0]     in_0,
  input  logic [WIDTH-1:0]     in_1,
  input  logic                 en,
  output logic [WIDTH-1:0]     data_out_q,
  output logic                 sel_q,
`ifdef MUX_PARITY_EN
  output logic                 parity,
  output logic                 parity_q,
`endif
  output logic [CNT_WIDTH-1:0] toggle_cnt
);

  // Continuous assign rather than if/else, so an X/Z select still resolves
  // to the common value when both inputs agree.
  assign data_out = en ? in_1 : in_0;

  logic cnt_sat;
  logic sel_change;

  assign cnt_sat    = &toggle_cnt;
  assign sel_change = (en != sel_q);

  // Registered copy of the mux output and select, plus saturating toggle count.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
      sel_q      <= 1'b0;
      toggle_cnt <= '0;
    end else begin
      data_out_q <= data_out;
      sel_q      <= en;
      if (sel_change && !cnt_sat)
        toggle_cnt <= toggle_cnt + CNT_WIDTH'(1);
    end
  end

`ifdef MUX_PARITY_EN
  assign parity = ^data_out;

  // Parity registered alongside data_out_q so the two stay cycle-aligned.
  always_ff @(posedge clk) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= parity;
  end
`endif

endmodule

// File: tb/tb_two_one_mux.sv
// Self-checking bench for two_one_mux. Expected values are pushed to a
// scoreboard queue as stimulus is driven and popped when the output is sampled.
// A second instance with CNT_WIDTH=4 shares the stimulus to exercise saturation.
module tb_two_one_mux;

  localparam int W = 64;

  logic          clk;
  logic          rst;
  logic          en;
  logic [W-1:0]  in_0, in_1;
  logic [W-1:0]  data_out, data_out_q;
  logic          sel_q;
  logic [15:0]   toggle_cnt;
  logic [W-1:0]  data_out4, data_out_q4;
  logic          sel_q4;
  logic [3:0]    toggle_cnt4;
`ifdef MUX_PARITY_EN
  logic          parity, parity_q, parity4, parity_q4;
`endif

  two_one_mux #(.WIDTH(W), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .data_out(data_out), .in_0(in_0), .in_1(in_1),
    .en(en), .data_out_q(data_out_q), .sel_q(sel_q),
`ifdef MUX_PARITY_EN
    .parity(parity), .parity_q(parity_q),
`endif
    .toggle_cnt(toggle_cnt)
  );

  two_one_mux #(.WIDTH(W), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .data_out(data_out4), .in_0(in_0), .in_1(in_1),
    .en(en), .data_out_q(data_out_q4), .sel_q(sel_q4),
`ifdef MUX_PARITY_EN
    .parity(parity4), .parity_q(parity_q4),
`endif
    .toggle_cnt(toggle_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [W-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_mis = 0;

  task automatic push(input string tag, input logic [W-1:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [W-1:0] obs);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_mis++;
      $error("FAIL sb_empty obs=%0h exp=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_mis++;
        $error("FAIL %s obs=%0h exp=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Advance to just past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int           k;
  logic [W-1:0] exp_dq;
  logic [W-1:0] mid_val;

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    in_0 = '0;
    in_1 = '0;
    tick();
    tick();

    // Reset state
    push("rst_dq", '0);      pop_chk(data_out_q);
    push("rst_sel", '0);     pop_chk(W'(sel_q));
    push("rst_cnt", '0);     pop_chk(W'(toggle_cnt));
    push("rst_cnt4", '0);    pop_chk(W'(toggle_cnt4));

    // Combinational follow, 8 phases, while reset is held (must not matter)
    in_0 = 64'd4213;
    in_1 = 64'd69230;
    for (int i = 0; i < 8; i++) begin
      en = (i % 2 == 0);
      push("comb_follow", en ? 64'd69230 : 64'd4213);
      #1;
      pop_chk(data_out);
      #9;
    end

    // Reset for 2 cycles with en=1, in_1 all-ones, then release
    tick();
    rst  = 1'b1;
    en   = 1'b1;
    in_1 = '1;
    for (int i = 0; i < 2; i++) begin
      tick();
      push("rst_hold_dq", '0);  pop_chk(data_out_q);
      push("rst_hold_do", '1);  pop_chk(data_out);
    end
    rst = 1'b0;
    tick();
    push("post_rst_dq", '1);   pop_chk(data_out_q);
    push("post_rst_sel", 1);   pop_chk(W'(sel_q));
    push("post_rst_cnt", 1);   pop_chk(W'(toggle_cnt));

    // Toggle every cycle for 10 cycles from a fresh reset
    rst = 1'b1;
    en  = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      en     = (i % 2 == 0);
      in_0   = 64'h1000 + W'(i);
      in_1   = 64'hA000_0000_0000_0000 + W'(i);
      exp_dq = en ? in_1 : in_0;
      tick();
      push("tog_dq", exp_dq);            pop_chk(data_out_q);
      push("tog_cnt", W'(i + 1));        pop_chk(W'(toggle_cnt));
    end
    push("tog_cnt4_10", 10);             pop_chk(W'(toggle_cnt4));

    // Hold en (last value 0) for 5 cycles: count frozen
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      push("hold_cnt", 10);              pop_chk(W'(toggle_cnt));
    end

    // 10 more toggles: 16-bit reaches 20, 4-bit saturates at 15
    for (int i = 0; i < 10; i++) begin
      en = (i % 2 == 0);
      tick();
      k = 11 + i;
      push("tog2_cnt", W'(k));                     pop_chk(W'(toggle_cnt));
      push("sat_cnt4", W'((k > 15) ? 15 : k));     pop_chk(W'(toggle_cnt4));
    end
    for (int i = 0; i < 3; i++) begin
      en = ~en;
      tick();
      push("sat_hold4", 15);                       pop_chk(W'(toggle_cnt4));
    end
    push("cnt_23", 23);                            pop_chk(W'(toggle_cnt));

    // Only the value present at the edge is captured
    en      = 1'b0;
    in_0    = 64'hDEAD_BEEF_0000_0001;
    #3;
    mid_val = 64'h0123_4567_89AB_CDEF;
    in_0    = mid_val;
    tick();
    push("edge_sample", mid_val);                  pop_chk(data_out_q);

    // X select with equal inputs resolves to the common value
    in_0 = 64'h5A5A;
    in_1 = 64'h5A5A;
    en   = 1'bx;
    push("x_sel_eq", 64'h5A5A);
    #1;
    pop_chk(data_out);

    // Mid-stream reset with en=1, in_1=69230
    en   = 1'b1;
    in_1 = 64'd69230;
    tick();
    rst = 1'b1;
    push("mid_rst_do_pre", 64'd69230);   #1; pop_chk(data_out);
    tick();
    push("mid_rst_do", 64'd69230);       pop_chk(data_out);
    push("mid_rst_dq", '0);              pop_chk(data_out_q);
    push("mid_rst_sel", '0);             pop_chk(W'(sel_q));
    push("mid_rst_cnt", '0);             pop_chk(W'(toggle_cnt));
    push("mid_rst_cnt4", '0);            pop_chk(W'(toggle_cnt4));
    rst = 1'b0;

`ifdef MUX_PARITY_EN
    en   = 1'b0;
    in_0 = 64'h7;
    push("par_7", 1);     #1; pop_chk(W'(parity));
    tick();
    push("parq_7", 1);    pop_chk(W'(parity_q));
    in_0 = 64'h3;
    push("par_3", 0);     #1; pop_chk(W'(parity));
    tick();
    push("parq_3", 0);    pop_chk(W'(parity_q));
`endif

    if (sb.size() != 0) begin
      n_vec++;
      n_mis++;
      $error("FAIL sb_leftover obs=%0d exp=0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
